// File: rtl/route_pkg.sv
// Shared types and defaults for the route/slice stream stage.
package route_pkg;

  localparam int DEF_DATA_W = 256;
  localparam int DEF_FEAT_W = 12;
  localparam int DEF_CH_W   = 11;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } route_state_t;

endpackage

// File: rtl/route_skid_buf.sv
// Two-entry valid/ready skid buffer; slot 0 is always the registered head.
module route_skid_buf
  import route_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic         single,
  output logic [W-1:0] head_data
);

  logic [1:0]   count_reg;
  logic [W-1:0] slot_reg [SKID_DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign full      = (count_reg == 2'(SKID_DEPTH));
  assign empty     = (count_reg == 2'd0);
  assign single    = (count_reg == 2'd1);
  assign head_data = slot_reg[0];
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= 2'd0;
      slot_reg[0] <= '0;
      slot_reg[1] <= '0;
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          slot_reg[count_reg[0]] <= push_data;
          count_reg              <= count_reg + 2'd1;
        end
        2'b01: begin
          slot_reg[0] <= slot_reg[1];
          count_reg   <= count_reg - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new beat lands behind whatever remains.
          if (count_reg == 2'd1) begin
            slot_reg[0] <= push_data;
          end else begin
            slot_reg[0] <= slot_reg[1];
            slot_reg[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/route_slice_stream.sv
// Route/slice stage: forwards a channel-beat window of every pixel, drops the rest.
// Optional ROUTE_STALL_CNT_EN adds a saturating output-stall cycle counter port.
module route_slice_stream
  import route_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FEAT_W = DEF_FEAT_W,
  parameter int CH_W   = DEF_CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              next_reg,
  input  logic [FEAT_W-1:0] row_num,
  input  logic [FEAT_W-1:0] col_num,
  input  logic [CH_W-1:0]   ch_beats,
  input  logic [CH_W-1:0]   slice_start,
  input  logic [CH_W-1:0]   slice_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
`ifdef ROUTE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  route_state_t      state_reg;
  logic [FEAT_W-1:0] row_num_reg, col_num_reg, cnt_row_reg, cnt_col_reg;
  logic [CH_W-1:0]   ch_beats_reg, slice_start_reg, cnt_cin_reg;
  logic [CH_W:0]     slice_end_reg;
  logic [CH_W:0]     sum_w, end_w;

  logic in_window, end_hit, last_cin, last_col, last_row, frame_last;
  logic accept, push, pop;
  logic skid_full, skid_empty, skid_single;
  logic [DATA_W:0] head_data;

  // Window end clamped to the pixel depth, one bit wider so start+len cannot overflow.
  assign sum_w = {1'b0, slice_start} + {1'b0, slice_len};
  assign end_w = (sum_w < {1'b0, ch_beats}) ? sum_w : {1'b0, ch_beats};

  assign in_window  = (cnt_cin_reg >= slice_start_reg) && ({1'b0, cnt_cin_reg} < slice_end_reg);
  assign end_hit    = (({1'b0, cnt_cin_reg} + (CH_W+1)'(1)) == slice_end_reg);
  assign last_cin   = (cnt_cin_reg == ch_beats_reg - CH_W'(1));
  assign last_col   = (cnt_col_reg == col_num_reg - FEAT_W'(1));
  assign last_row   = (cnt_row_reg == row_num_reg - FEAT_W'(1));
  assign frame_last = last_cin & last_col & last_row;

  assign s_ready = (state_reg == ST_RUN) & (~skid_full | ~in_window);
  assign accept  = s_valid & s_ready;
  assign push    = accept & in_window;
  assign pop     = m_valid & m_ready;

  assign m_valid = ~skid_empty;
  assign m_data  = head_data[DATA_W-1:0];
  assign m_last  = m_valid & head_data[DATA_W];
  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);

  route_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (next_reg),
    .push      (push),
    .push_data ({end_hit & last_col & last_row, s_data}),
    .pop       (pop),
    .full      (skid_full),
    .empty     (skid_empty),
    .single    (skid_single),
    .head_data (head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      row_num_reg     <= '0;
      col_num_reg     <= '0;
      ch_beats_reg    <= '0;
      slice_start_reg <= '0;
      slice_end_reg   <= '0;
      cnt_row_reg     <= '0;
      cnt_col_reg     <= '0;
      cnt_cin_reg     <= '0;
    end else if (next_reg) begin
      state_reg   <= ST_IDLE;
      cnt_row_reg <= '0;
      cnt_col_reg <= '0;
      cnt_cin_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            row_num_reg     <= row_num;
            col_num_reg     <= col_num;
            ch_beats_reg    <= ch_beats;
            slice_start_reg <= slice_start;
            slice_end_reg   <= end_w;
            cnt_row_reg     <= '0;
            cnt_col_reg     <= '0;
            cnt_cin_reg     <= '0;
            state_reg       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_cin) begin
              cnt_cin_reg <= '0;
              if (last_col) begin
                cnt_col_reg <= '0;
                cnt_row_reg <= last_row ? '0 : cnt_row_reg + FEAT_W'(1);
              end else begin
                cnt_col_reg <= cnt_col_reg + FEAT_W'(1);
              end
            end else begin
              cnt_cin_reg <= cnt_cin_reg + CH_W'(1);
            end
            if (frame_last) state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave as soon as the final queued beat is being taken this cycle.
          if (skid_empty | (skid_single & pop)) state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef ROUTE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (next_reg | (start & (state_reg == ST_IDLE))) begin
      stall_cnt <= '0;
    end else if (busy & m_valid & ~m_ready & (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_route_slice_stream.sv
// Self-checking bench for route_slice_stream against a queue-based slicing model.
module tb_route_slice_stream;

  localparam int DW = 64;
  localparam int FW = 12;
  localparam int CW = 11;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          next_reg = 1'b0;
  logic [FW-1:0] row_num = '0, col_num = '0;
  logic [CW-1:0] ch_beats = '0, slice_start = '0, slice_len = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic          done;
`ifdef ROUTE_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  route_slice_stream #(.DATA_W(DW), .FEAT_W(FW), .CH_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .next_reg(next_reg),
    .row_num(row_num), .col_num(col_num), .ch_beats(ch_beats),
    .slice_start(slice_start), .slice_len(slice_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
`ifdef ROUTE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  int n_in, last_in_cyc, last_pop_cyc, done_cnt, done_cyc;
  int m_stall, in_stall, stable_viol, mvalid_seen;

  task automatic set_cfg(input int r, input int c, input int ch, input int st, input int len);
    row_num = FW'(r); col_num = FW'(c); ch_beats = CW'(ch);
    slice_start = CW'(st); slice_len = CW'(len);
  endtask

  // Reference: beat k of each pixel goes out iff st <= k < st+len (k < ch is implicit).
  task automatic build_exp(input int r, input int c, input int ch, input int st, input int len);
    exp_q = {};
    for (int p = 0; p < r * c; p++)
      for (int k = 0; k < ch; k++)
        if (k >= st && k < st + len) exp_q.push_back(in_q[p * ch + k]);
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // rmode: 0 m_ready=1, 1 toggle 1-0, 2 random
  task automatic run_frame(input int r, input int c, input int ch, input int st, input int len,
                           input int rmode, input bit rvalid, input int restart_at);
    int total;
    bit prev_stall;
    bit restarted;
    logic [DW-1:0] prev_d;
    logic prev_l;
    total = r * c * ch;
    prev_stall = 0; restarted = 0; prev_d = '0; prev_l = 0;
    in_q = {};
    for (int i = 0; i < total; i++) in_q.push_back({$urandom, $urandom});
    got_d = {}; got_l = {};
    n_in = 0; last_in_cyc = -1; last_pop_cyc = -1; done_cnt = 0; done_cyc = -1;
    m_stall = 0; in_stall = 0; stable_viol = 0; mvalid_seen = 0;
    @(negedge clk);
    set_cfg(r, c, ch, st, len);
    start = 1'b1;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart_at >= 0 && !restarted && n_in == restart_at) begin
        start = 1'b1; restarted = 1;
        set_cfg(r + 1, c + 1, ch + 1, 0, ch + 1);
      end
      s_valid = (n_in < total) && (!rvalid || $urandom_range(0, 3) != 0);
      s_data  = s_valid ? in_q[n_in] : {$urandom, $urandom};
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stable_viol++;
      prev_stall = m_valid && !m_ready; prev_d = m_data; prev_l = m_last;
      if (busy && m_valid && !m_ready) m_stall++;
      if (busy && s_valid && !s_ready) in_stall++;
      if (m_valid) mvalid_seen++;
      if (s_valid && s_ready) begin n_in++; last_in_cyc = cyc; end
      if (m_valid && m_ready) begin
        got_d.push_back(m_data); got_l.push_back(m_last); last_pop_cyc = cyc;
        $display("beat %0d data=%h last=%0b", got_d.size() - 1, m_data, m_last);
      end
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
    end
    @(negedge clk);
    s_valid = 1'b0; start = 1'b0; m_ready = 1'b1;
    set_cfg(r, c, ch, st, len);
    build_exp(r, c, ch, st, len);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, m_valid, m_last, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {s_ready, m_valid, m_last, busy, done});
    end
    n_cmp++;
    if (m_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", m_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(2, 2, 4, 2, 2, 0, 0, -1);
    n_cmp++;
    if (got_d.size() !== 8) begin n_fail++; $display("FAIL basic_count got %0d want 8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, got_d[i], exp_q[i]); end
      n_cmp++;
      if (got_l[i] !== (i == 7)) begin n_fail++; $display("FAIL basic_last[%0d] got %0b want %0b", i, got_l[i], i == 7); end
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
    n_cmp++;
    if (done_cyc !== last_pop_cyc + 1) begin n_fail++; $display("FAIL basic_done_time got %0d want %0d", done_cyc, last_pop_cyc + 1); end
    n_cmp++;
    if (in_stall !== 0) begin n_fail++; $display("FAIL basic_in_stall got %0d want 0", in_stall); end
  endtask

  task automatic test_backpressure();
    run_frame(2, 2, 4, 2, 2, 1, 0, -1);
    n_cmp++;
    if (got_d.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_d.size(), exp_q.size()); end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, got_d[i], exp_q[i]); end
    end
    n_cmp++;
    if (stable_viol !== 0) begin n_fail++; $display("FAIL bp_stable got %0d want 0", stable_viol); end
    n_cmp++;
    if (m_stall == 0) begin n_fail++; $display("FAIL bp_stalls got %0d want >0", m_stall); end
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
`ifdef ROUTE_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt !== 32'(m_stall)) begin n_fail++; $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, m_stall); end
`endif
  endtask

  task automatic test_clamp();
    run_frame(2, 2, 4, 3, 5, 0, 0, -1);
    n_cmp++;
    if (got_d.size() !== 4) begin n_fail++; $display("FAIL clamp_count got %0d want 4", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL clamp_data[%0d] got %h want %h", i, got_d[i], exp_q[i]); end
      n_cmp++;
      if (got_l[i] !== (i == 3)) begin n_fail++; $display("FAIL clamp_last[%0d] got %0b want %0b", i, got_l[i], i == 3); end
    end
    run_frame(2, 2, 4, 4, 2, 0, 0, -1);
    n_cmp++;
    if (mvalid_seen !== 0) begin n_fail++; $display("FAIL empty_mvalid got %0d want 0", mvalid_seen); end
    n_cmp++;
    if (n_in !== 16) begin n_fail++; $display("FAIL empty_inputs got %0d want 16", n_in); end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== last_in_cyc + 2) begin
      n_fail++; $display("FAIL empty_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, last_in_cyc + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    int acc;
    acc = 0;
    @(negedge clk);
    set_cfg(2, 2, 4, 2, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && acc < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      s_valid = 1'b1; s_data = {$urandom, $urandom}; m_ready = 1'b1;
      #1;
      if (s_ready) acc++;
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    n_cmp++;
    if ({s_ready, m_valid, m_last, busy, done} !== 5'b0 || m_data !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs got %b/%h want 00000/0", {s_ready, m_valid, m_last, busy, done}, m_data);
    end
    @(negedge clk); rst_n = 1'b1;
    run_frame(2, 2, 4, 2, 2, 2, 1, -1);
    n_cmp++;
    if (got_d.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count got %0d want %0d", got_d.size(), exp_q.size()); end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_data[%0d] got %h want %h", i, got_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_next_reg();
    int acc, after, dones;
    acc = 0; after = 0; dones = 0;
    in_q = {};
    for (int i = 0; i < 16; i++) in_q.push_back({$urandom, $urandom});
    @(negedge clk);
    set_cfg(2, 2, 4, 2, 2);
    start = 1'b1;
    for (int cyc = 0; cyc < 200 && after < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      s_valid = (acc < 16);
      s_data = s_valid ? in_q[acc] : '0;
      m_ready = (acc < 14);
      #1;
      if (done) dones++;
      if (s_valid && s_ready) acc++;
      else if (acc == 16) after++;
    end
    n_cmp++;
    if ({busy, m_valid, s_ready} !== 3'b110) begin n_fail++; $display("FAIL nreg_drain got %b want 110", {busy, m_valid, s_ready}); end
    n_cmp++;
    if (m_data !== in_q[14]) begin n_fail++; $display("FAIL nreg_head got %h want %h", m_data, in_q[14]); end
    @(negedge clk); next_reg = 1'b1;
    @(negedge clk); next_reg = 1'b0;
    #1;
    n_cmp++;
    if ({busy, m_valid} !== 2'b00) begin n_fail++; $display("FAIL nreg_idle got %b want 00", {busy, m_valid}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL nreg_done got %0d want 0", dones); end
    m_ready = 1'b1;
  endtask

  task automatic test_restart_ignored();
    run_frame(2, 2, 4, 2, 2, 0, 1, 6);
    n_cmp++;
    if (n_in !== 16 || done_cnt !== 1) begin n_fail++; $display("FAIL restart_frame got in=%0d done=%0d want 16/1", n_in, done_cnt); end
    n_cmp++;
    if (got_d.size() !== exp_q.size()) begin n_fail++; $display("FAIL restart_count got %0d want %0d", got_d.size(), exp_q.size()); end
    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_d[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart_data[%0d] got %h want %h", i, got_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int r, c, ch, st, len, want_done;
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(1, 3); c = $urandom_range(1, 3); ch = $urandom_range(1, 6);
      st = $urandom_range(0, 6); len = $urandom_range(0, 6);
      run_frame(r, c, ch, st, len, 2, 1, -1);
      $display("frame r=%0d c=%0d ch=%0d st=%0d len=%0d in=%0d out=%0d", r, c, ch, st, len, n_in, got_d.size());
      n_cmp++;
      if (got_d.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got_d.size(), exp_q.size()); end
      for (int i = 0; i < got_d.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
          n_fail++; $display("FAIL rand_beat[%0d] got %h/%0b want %h/%0b", i, got_d[i], got_l[i], exp_q[i], i == exp_q.size() - 1);
        end
      end
      want_done = max2(last_pop_cyc + 1, last_in_cyc + 2);
      n_cmp++;
      if (done_cnt !== 1 || done_cyc !== want_done) begin
        n_fail++; $display("FAIL rand_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d", done_cnt, done_cyc, want_done);
      end
      n_cmp++;
      if (stable_viol !== 0) begin n_fail++; $display("FAIL rand_stable got %0d want 0", stable_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_reset_mid_run();
    test_next_reg();
    test_restart_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
